// File: rtl/adc_reader_pkg.sv
// Shared types and frame geometry for the serial ADC reader.
package adc_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_BITS  = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: idles high, toggles every CLK_DIV cycles while enabled
// (first toggle is a fall). sclk_rise is high in the cycle whose closing edge
// drives SCLK 0->1, so the consumer samples on that same edge.
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic adc_sclk,
  output logic sclk_rise
);

  localparam int                 DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick    = enable && (r_div_cnt == DIV_LAST);
  assign sclk_rise = w_tick && !r_sclk;
  assign adc_sclk  = r_sclk;

  // Half-period divider; held cleared with SCLK parked high when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b1;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b1;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// Serial ADC frame reader: IDLE -> CONV (16 SCLK cycles, MSB first) -> QUIET.
// Optional leading-zero check on the top 4 frame bits is enabled by defining
// ADC_LEAD_ZERO_CHECK_EN; without it adc_frame_err is tied low.
module adc_reader
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adc_begin,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] adc_data,
  output logic                 adc_valid,
  output logic                 adc_busy,
  output logic                 adc_frame_err
);

  localparam int               BIT_W    = $clog2(FRAME_BITS + 1);
  localparam int               QW       = $clog2(QUIET_CYCLES + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [QW-1:0]    Q_LAST   = QW'(QUIET_CYCLES - 1);

  state_t                  r_state;
  logic                    r_cs_n;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [QW-1:0]           r_quiet_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]    r_data;
  logic                    r_valid;

  logic                    w_sclk_en;
  logic                    w_rise;
  logic                    w_last;
  logic [FRAME_BITS-1:0]   w_shift_next;
  logic                    w_unused_lead;

  assign w_sclk_en    = (r_state == CONV);
  assign w_shift_next = {r_shift[FRAME_BITS-2:0], adc_sdata};
  assign w_last       = w_sclk_en && w_rise && (r_bit_cnt == LAST_BIT);
  // Top shift bit falls out on the next shift and is never observed.
  assign w_unused_lead = ^{r_shift[FRAME_BITS-1], w_shift_next[FRAME_BITS-1 -: LEAD_BITS]};

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (w_sclk_en),
    .adc_sclk  (adc_sclk),
    .sclk_rise (w_rise)
  );

  assign adc_cs_n  = r_cs_n;
  assign adc_data  = r_data;
  assign adc_valid = r_valid;
  assign adc_busy  = (r_state != IDLE);

  // Frame FSM with shift register, sample capture and valid strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cs_n      <= 1'b1;
      r_bit_cnt   <= '0;
      r_quiet_cnt <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (adc_begin) begin
            r_state   <= CONV;
            r_cs_n    <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        CONV: begin
          if (w_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last) begin
              r_cs_n      <= 1'b1;
              r_data      <= w_shift_next[DATA_BITS-1:0];
              r_valid     <= 1'b1;
              r_quiet_cnt <= '0;
              r_state     <= QUIET;
            end
          end
        end
        QUIET: begin
          if (r_quiet_cnt == Q_LAST) begin
            r_state <= IDLE;
          end else begin
            r_quiet_cnt <= r_quiet_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADC_LEAD_ZERO_CHECK_EN
  logic r_frame_err;

  // Flag nonzero leading bits of each completed frame; held until next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
    end else if (w_last) begin
      r_frame_err <= (w_shift_next[FRAME_BITS-1 -: LEAD_BITS] != '0);
    end
  end

  assign adc_frame_err = r_frame_err;
`else
  assign adc_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_reader.sv
// Scoreboard bench for adc_reader: ADC models serve 16-bit words; expected
// samples are queued at frame start and checked when adc_valid is seen.
module tb_adc_reader;

  localparam int DIV_A  = 4;
  localparam int QA     = 8;
  localparam int PER_A  = 32 * DIV_A + QA + 1;
  localparam int DIV_B  = 1;
  localparam int QB     = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic        a_begin = 1'b0, a_sdata = 1'b0;
  logic        a_cs_n, a_sclk, a_valid, a_busy, a_err;
  logic [11:0] a_data;
  logic        b_begin = 1'b0, b_sdata = 1'b0;
  logic        b_cs_n, b_sclk, b_valid, b_busy, b_err;
  logic [11:0] b_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  adc_reader #(.CLK_DIV(DIV_A), .QUIET_CYCLES(QA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .adc_begin(a_begin), .adc_sdata(a_sdata),
    .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .adc_data(a_data), .adc_valid(a_valid),
    .adc_busy(a_busy), .adc_frame_err(a_err)
  );

  adc_reader #(.CLK_DIV(DIV_B), .QUIET_CYCLES(QB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .adc_begin(b_begin), .adc_sdata(b_sdata),
    .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .adc_data(b_data), .adc_valid(b_valid),
    .adc_busy(b_busy), .adc_frame_err(b_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sample is the low 12 bits; error flag is nonzero top nibble when enabled.
  function automatic logic [11:0] ref_data(input logic [15:0] w);
    return w[11:0];
  endfunction

  function automatic logic ref_err(input logic [15:0] w);
`ifdef ADC_LEAD_ZERO_CHECK_EN
    return (w[15:12] != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- ADC models ----------------
  logic [15:0] serve_a[$], serve_b[$], exp_a[$], exp_b[$];
  logic [15:0] word_a, word_b;
  int idx_a = 0, idx_b = 0, n_frames_a = 0;

  initial forever begin
    @(negedge a_cs_n);
    if (reset_n) begin
      word_a = (serve_a.size() > 0) ? serve_a.pop_front() : 16'($urandom);
      idx_a = 16;
      n_frames_a++;
      exp_a.push_back(word_a);
    end
  end
  initial forever begin
    @(negedge a_sclk);
    if (!a_cs_n && idx_a > 0) begin
      idx_a--;
      a_sdata = word_a[idx_a];
    end
  end
  initial forever begin
    @(negedge b_cs_n);
    if (reset_n) begin
      word_b = (serve_b.size() > 0) ? serve_b.pop_front() : 16'($urandom);
      idx_b = 16;
      exp_b.push_back(word_b);
    end
  end
  initial forever begin
    @(negedge b_sclk);
    if (!b_cs_n && idx_b > 0) begin
      idx_b--;
      b_sdata = word_b[idx_b];
    end
  end

  // ---------------- monitors ----------------
  int low_a = 0, rise_a = 0, hi_a = 0, n_valid_a = 0;
  logic prev_sclk_a = 1'b1, prev_cs_a = 1'b1, seen_a = 1'b0;
  logic [11:0] last_a = '0;
  int valid_cyc_a[$];
  logic [15:0] e_a;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      low_a = 0; rise_a = 0; hi_a = 0; seen_a = 1'b0;
      prev_sclk_a = 1'b1; prev_cs_a = 1'b1; last_a = '0;
    end else begin
      if (!a_cs_n) low_a++;
      else hi_a++;
      if (a_sclk && !prev_sclk_a) rise_a++;
      if (!a_cs_n && prev_cs_a && seen_a) begin
        check("cs_gap_ok_a", 32'(hi_a >= QA), 32'd1);
        seen_a = 1'b0;
      end
      prev_sclk_a = a_sclk;
      prev_cs_a = a_cs_n;
      if (a_valid) begin
        n_valid_a++;
        valid_cyc_a.push_back(cyc);
        if (exp_a.size() == 0) begin
          check("unexpected_valid_a", 32'd1, 32'd0);
        end else begin
          e_a = exp_a.pop_front();
          check("data_a", 32'(a_data), 32'(ref_data(e_a)));
          check("err_a", 32'(a_err), 32'(ref_err(e_a)));
          check("cs_low_len_a", low_a, 32 * DIV_A);
          check("sclk_rises_a", rise_a, 16);
          last_a = ref_data(e_a);
        end
        low_a = 0; rise_a = 0; hi_a = 1; seen_a = 1'b1;
      end else if (a_data !== last_a) begin
        check("data_hold_a", 32'(a_data), 32'(last_a));
      end
    end
  end

  int low_b = 0, n_valid_b = 0;
  logic [15:0] e_b;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      low_b = 0;
    end else begin
      if (!b_cs_n) low_b++;
      if (b_valid) begin
        n_valid_b++;
        if (exp_b.size() == 0) begin
          check("unexpected_valid_b", 32'd1, 32'd0);
        end else begin
          e_b = exp_b.pop_front();
          check("data_b", 32'(b_data), 32'(ref_data(e_b)));
          check("err_b", 32'(b_err), 32'(ref_err(e_b)));
          check("cs_low_len_b", low_b, 32 * DIV_B);
        end
        low_b = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid_a(input int target);
    int n = 0;
    while (n_valid_a < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n_valid_a < target) check("timeout_valid_a", n_valid_a, target);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    @(posedge clk);
    while (a_busy && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (a_busy) check("timeout_idle_a", 32'(a_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic frame_a(input logic [15:0] w);
    int target;
    target = n_valid_a + 1;
    serve_a.push_back(w);
    @(negedge clk) a_begin = 1'b1;
    @(negedge clk) a_begin = 1'b0;
    wait_valid_a(target);
    wait_idle_a();
  endtask

  task automatic frame_b(input logic [15:0] w);
    int target, n;
    target = n_valid_b + 1;
    n = 0;
    serve_b.push_back(w);
    @(negedge clk) b_begin = 1'b1;
    @(negedge clk) b_begin = 1'b0;
    while (n_valid_b < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n_valid_b < target) check("timeout_valid_b", n_valid_b, target);
    repeat (QB + 3) @(negedge clk);
  endtask

  task automatic wait_rise_a(input int r);
    int n = 0;
    while (rise_a < r && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (rise_a < r) check("timeout_rise_a", rise_a, r);
  endtask

  // ---------------- test sequence ----------------
  int fr0, vl0, k;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_cs_n", 32'(a_cs_n), 32'd1);
    check("rst_sclk", 32'(a_sclk), 32'd1);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames
    frame_a(16'h0ABC);
    check("abc_data", 32'(a_data), 32'h0ABC);
    check("abc_err", 32'(a_err), 32'd0);
    frame_a(16'h8123);
    check("lead_data", 32'(a_data), 32'h0123);
`ifdef ADC_LEAD_ZERO_CHECK_EN
    check("lead_err", 32'(a_err), 32'd1);
`else
    check("lead_err", 32'(a_err), 32'd0);
`endif

    // Randomized frames with random idle gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      frame_a(16'($urandom));
    end

    // Held begin: three back-to-back frames
    k = valid_cyc_a.size();
    for (int i = 0; i < 3; i++) serve_a.push_back(16'($urandom));
    vl0 = n_valid_a;
    @(negedge clk) a_begin = 1'b1;
    wait_valid_a(vl0 + 3);
    @(negedge clk) a_begin = 1'b0;
    wait_idle_a();
    if (valid_cyc_a.size() >= k + 3) begin
      check("b2b_period_1", valid_cyc_a[k+1] - valid_cyc_a[k], PER_A);
      check("b2b_period_2", valid_cyc_a[k+2] - valid_cyc_a[k+1], PER_A);
    end else begin
      check("b2b_count", valid_cyc_a.size() - k, 3);
    end

    // Extra begin mid-frame is ignored
    fr0 = n_frames_a;
    vl0 = n_valid_a;
    serve_a.push_back(16'h0357);
    @(negedge clk) a_begin = 1'b1;
    @(negedge clk) a_begin = 1'b0;
    wait_rise_a(5);
    @(negedge clk) a_begin = 1'b1;
    @(negedge clk) a_begin = 1'b0;
    wait_valid_a(vl0 + 1);
    wait_idle_a();
    repeat (20) @(negedge clk);
    check("ignored_frames", n_frames_a - fr0, 1);
    check("ignored_valids", n_valid_a - vl0, 1);
    check("ignored_data", 32'(a_data), 32'h0357);

    // Reset at SCLK rise 9 aborts the frame
    vl0 = n_valid_a;
    serve_a.push_back(16'h0FED);
    @(negedge clk) a_begin = 1'b1;
    @(negedge clk) a_begin = 1'b0;
    wait_rise_a(9);
    #2 reset_n = 1'b0;
    #1;
    exp_a.delete();
    check("abort_cs_n", 32'(a_cs_n), 32'd1);
    check("abort_sclk", 32'(a_sclk), 32'd1);
    check("abort_valid", 32'(a_valid), 32'd0);
    check("abort_data", 32'(a_data), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_valid", n_valid_a - vl0, 0);
    check("abort_idle_cs", 32'(a_cs_n), 32'd1);
    frame_a(16'h0456);
    check("post_reset_data", 32'(a_data), 32'h0456);

    // CLK_DIV=1 instance
    frame_b(16'h0FFF);
    check("div1_fff", 32'(b_data), 32'h0FFF);
    frame_b(16'h0000);
    check("div1_000", 32'(b_data), 32'h0000);

    check("sb_empty_a", exp_a.size(), 0);
    check("sb_empty_b", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
